preg_ready_table: RTL and testbench

Parametrised physical-register readiness table for the dispatch stage. It tracks one state per physical register: busy, speculatively ready, or ready. State is set by dispatch, by writeback wakeup, by rename-walk recovery and by speculative load wakeup with cancel. Issue-queue read ports get same-cycle bypassed readiness and a speculative flag. A registered busy-entry count is also kept for dispatch throttling.

---
 rtl/preg_ready_table.sv | 192 +++++++++++++++++++
 tb/tb_preg_ready_table.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/preg_ready_table.sv
// preg_ready_table: physical-register readiness table for the dispatch stage.
//
// Each physical register is BUSY, READY or (optionally) speculatively ready. Dispatch marks
// an entry busy; writeback and rename-walk recovery mark it ready; a speculative load
// wakeup marks it SPEC for SPEC_DELAY cycles, during which a cancel on the owning load port
// sends it back to BUSY. Preg 0 is hard-wired READY.
//
// Build option: define PREG_READY_SPEC_WAKEUP_EN to enable the SPEC state. Without it the
// spec_* inputs are ignored, reg_spec is 0 and each entry is a single busy bit.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   dis_en/dis_rd, redirect       dispatch allocations (masked by redirect)
//   wb_en/wb_we/wb_rd             writeback wakeups
//   walk, walk_en/walk_we/walk_prd  rename-walk recovery to READY
//   spec_en/spec_rd/spec_cancel   speculative load wakeups and their cancels
//   preg -> reg_en/reg_spec       readiness query ports with same-cycle bypass
//   busy_count                    registered count of BUSY entries
module preg_ready_table #(
    parameter int unsigned PREG_SIZE  = 128,
    parameter int unsigned DIS_WIDTH  = 4,
    parameter int unsigned WB_PORTS   = 6,
    parameter int unsigned WALK_PORTS = 4,
    parameter int unsigned RD_PORTS   = 8,
    parameter int unsigned SPEC_PORTS = 2,
    parameter int unsigned SPEC_DELAY = 2,
    localparam int unsigned PREG_W    = $clog2(PREG_SIZE),
    localparam int unsigned CNT_BW    = $clog2(PREG_SIZE + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [DIS_WIDTH-1:0]                  dis_en,
    input  logic [DIS_WIDTH-1:0][PREG_W-1:0]      dis_rd,
    input  logic                                  redirect,
    input  logic [WB_PORTS-1:0]                   wb_en,
    input  logic [WB_PORTS-1:0]                   wb_we,
    input  logic [WB_PORTS-1:0][PREG_W-1:0]       wb_rd,
    input  logic                                  walk,
    input  logic [WALK_PORTS-1:0]                 walk_en,
    input  logic [WALK_PORTS-1:0]                 walk_we,
    input  logic [WALK_PORTS-1:0][PREG_W-1:0]     walk_prd,
    input  logic [SPEC_PORTS-1:0]                 spec_en,
    input  logic [SPEC_PORTS-1:0][PREG_W-1:0]     spec_rd,
    input  logic [SPEC_PORTS-1:0]                 spec_cancel,
    input  logic [RD_PORTS-1:0][PREG_W-1:0]       preg,
    output logic [RD_PORTS-1:0]                   reg_en,
    output logic [RD_PORTS-1:0]                   reg_spec,
    output logic [CNT_BW-1:0]                     busy_count
);

    // One-hot per-preg event decode; bit 0 is cleared so preg 0 ignores every event.
    logic [PREG_SIZE-1:0] dis_hit;
    logic [PREG_SIZE-1:0] rdy_hit;
    logic [CNT_BW-1:0]    busy_count_d;

    always_comb begin
        dis_hit = '0;
        rdy_hit = '0;
        for (int unsigned i = 0; i < DIS_WIDTH; i++) begin
            if (dis_en[i] && !redirect) dis_hit[dis_rd[i]] = 1'b1;
        end
        for (int unsigned i = 0; i < WB_PORTS; i++) begin
            if (wb_en[i] && wb_we[i]) rdy_hit[wb_rd[i]] = 1'b1;
        end
        for (int unsigned i = 0; i < WALK_PORTS; i++) begin
            if (walk && walk_en[i] && walk_we[i]) rdy_hit[walk_prd[i]] = 1'b1;
        end
        dis_hit[0] = 1'b0;
        rdy_hit[0] = 1'b0;
    end

`ifdef PREG_READY_SPEC_WAKEUP_EN
    localparam int unsigned SP_W  = (SPEC_PORTS > 1) ? $clog2(SPEC_PORTS) : 1;
    localparam int unsigned DLY_W = $clog2(SPEC_DELAY + 1);

    typedef enum logic [1:0] {StReady, StBusy, StSpec} pstate_e;

    pstate_e           state_q [PREG_SIZE];
    pstate_e           state_d [PREG_SIZE];
    logic [SP_W-1:0]   port_q  [PREG_SIZE];
    logic [SP_W-1:0]   port_d  [PREG_SIZE];
    logic [DLY_W-1:0]  cnt_q   [PREG_SIZE];
    logic [DLY_W-1:0]  cnt_d   [PREG_SIZE];

    // Uncancelled speculative hits; lowest port wins. A wakeup cancelled in its own cycle
    // is simply dropped.
    logic [PREG_SIZE-1:0] spec_hit;
    logic [SP_W-1:0]      spec_src [PREG_SIZE];

    always_comb begin
        spec_hit = '0;
        for (int unsigned p = 0; p < PREG_SIZE; p++) spec_src[p] = '0;
        for (int unsigned j = 0; j < SPEC_PORTS; j++) begin
            if (spec_en[j] && !spec_cancel[j] && !spec_hit[spec_rd[j]]) begin
                spec_hit[spec_rd[j]] = 1'b1;
                spec_src[spec_rd[j]] = SP_W'(j);
            end
        end
        spec_hit[0] = 1'b0;
    end

    always_comb begin
        busy_count_d = '0;
        for (int unsigned p = 0; p < PREG_SIZE; p++) begin
            state_d[p] = state_q[p];
            port_d[p]  = port_q[p];
            cnt_d[p]   = cnt_q[p];
            if (p == 0) begin
                state_d[p] = StReady;
            end else if (dis_hit[p]) begin
                state_d[p] = StBusy;
            end else if (rdy_hit[p]) begin
                state_d[p] = StReady;
            end else if (spec_hit[p]) begin
                state_d[p] = StSpec;
                port_d[p]  = spec_src[p];
                cnt_d[p]   = DLY_W'(SPEC_DELAY);
            end else if (state_q[p] == StSpec) begin
                if (spec_cancel[port_q[p]]) begin
                    state_d[p] = StBusy;
                end else if (cnt_q[p] == DLY_W'(1)) begin
                    state_d[p] = StReady;
                end else begin
                    cnt_d[p] = cnt_q[p] - DLY_W'(1);
                end
            end
            if (state_d[p] == StBusy) busy_count_d = busy_count_d + CNT_BW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned p = 0; p < PREG_SIZE; p++) begin
                state_q[p] <= StReady;
                port_q[p]  <= '0;
                cnt_q[p]   <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < PREG_SIZE; p++) begin
                state_q[p] <= state_d[p];
                port_q[p]  <= port_d[p];
                cnt_q[p]   <= cnt_d[p];
            end
        end
    end

    // A SPEC entry whose load is cancelled this cycle must not be read, even with bypass.
    always_comb begin
        for (int unsigned i = 0; i < RD_PORTS; i++) begin
            reg_en[i]   = ((state_q[preg[i]] != StBusy) || rdy_hit[preg[i]] || spec_hit[preg[i]])
                          && !(state_q[preg[i]] == StSpec && spec_cancel[port_q[preg[i]]]);
            reg_spec[i] = reg_en[i] && !rdy_hit[preg[i]]
                          && ((state_q[preg[i]] == StSpec) || spec_hit[preg[i]]);
        end
    end
`else
    logic [PREG_SIZE-1:0] busy_q;
    logic [PREG_SIZE-1:0] busy_d;
    logic                 unused_spec;

    assign unused_spec = ^{spec_en, spec_rd, spec_cancel};

    always_comb begin
        busy_d       = dis_hit | (busy_q & ~rdy_hit);
        busy_count_d = CNT_BW'($countones(busy_d));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < RD_PORTS; i++) begin
            reg_en[i] = !busy_q[preg[i]] || rdy_hit[preg[i]];
        end
        reg_spec = '0;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_count <= '0;
        end else begin
            busy_count <= busy_count_d;
        end
    end

endmodule

// File: tb/tb_preg_ready_table.sv
module tb_preg_ready_table;

    localparam int PREG_SIZE  = 128;
    localparam int DIS_WIDTH  = 4;
    localparam int WB_PORTS   = 6;
    localparam int WALK_PORTS = 4;
    localparam int RD_PORTS   = 8;
    localparam int SPEC_PORTS = 2;
    localparam int SPEC_DELAY = 2;
    localparam int PREG_W     = $clog2(PREG_SIZE);
    localparam int CNT_BW     = $clog2(PREG_SIZE + 1);

    logic                              clk = 1'b0;
    logic                              rst;
    logic [DIS_WIDTH-1:0]              dis_en;
    logic [DIS_WIDTH-1:0][PREG_W-1:0]  dis_rd;
    logic                              redirect;
    logic [WB_PORTS-1:0]               wb_en;
    logic [WB_PORTS-1:0]               wb_we;
    logic [WB_PORTS-1:0][PREG_W-1:0]   wb_rd;
    logic                              walk;
    logic [WALK_PORTS-1:0]             walk_en;
    logic [WALK_PORTS-1:0]             walk_we;
    logic [WALK_PORTS-1:0][PREG_W-1:0] walk_prd;
    logic [SPEC_PORTS-1:0]             spec_en;
    logic [SPEC_PORTS-1:0][PREG_W-1:0] spec_rd;
    logic [SPEC_PORTS-1:0]             spec_cancel;
    logic [RD_PORTS-1:0][PREG_W-1:0]   preg;
    logic [RD_PORTS-1:0]               reg_en;
    logic [RD_PORTS-1:0]               reg_spec;
    logic [CNT_BW-1:0]                 busy_count;

    preg_ready_table dut (
        .clk        (clk),
        .rst        (rst),
        .dis_en     (dis_en),
        .dis_rd     (dis_rd),
        .redirect   (redirect),
        .wb_en      (wb_en),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .walk       (walk),
        .walk_en    (walk_en),
        .walk_we    (walk_we),
        .walk_prd   (walk_prd),
        .spec_en    (spec_en),
        .spec_rd    (spec_rd),
        .spec_cancel(spec_cancel),
        .preg       (preg),
        .reg_en     (reg_en),
        .reg_spec   (reg_spec),
        .busy_count (busy_count)
    );

    always #5 clk = ~clk;

    // Reference model: kind 0=ready 1=busy 2=spec; a spec entry remembers its load port
    // and the last cycle number in which it is still cancellable.
    int m_kind [PREG_SIZE];
    int m_port [PREG_SIZE];
    int m_last [PREG_SIZE];
    int n_kind [PREG_SIZE];
    int n_port [PREG_SIZE];
    int n_last [PREG_SIZE];
    int cyc;
    int n_tests;
    int n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit m_dis_hit(int p);
        if (p == 0 || redirect) return 1'b0;
        for (int i = 0; i < DIS_WIDTH; i++)
            if (dis_en[i] && int'(dis_rd[i]) == p) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_rdy_hit(int p);
        if (p == 0) return 1'b0;
        for (int i = 0; i < WB_PORTS; i++)
            if (wb_en[i] && wb_we[i] && int'(wb_rd[i]) == p) return 1'b1;
        for (int i = 0; i < WALK_PORTS; i++)
            if (walk && walk_en[i] && walk_we[i] && int'(walk_prd[i]) == p) return 1'b1;
        return 1'b0;
    endfunction

    // Port of the winning uncancelled speculative wakeup for p, or -1.
    function automatic int m_spec_src(int p);
`ifdef PREG_READY_SPEC_WAKEUP_EN
        if (p == 0) return -1;
        for (int j = 0; j < SPEC_PORTS; j++)
            if (spec_en[j] && !spec_cancel[j] && int'(spec_rd[j]) == p) return j;
`endif
        if (p < 0) return -1;
        return -1;
    endfunction

    function automatic int m_busy_total();
        int n = 0;
        for (int p = 0; p < PREG_SIZE; p++) if (m_kind[p] == 1) n++;
        return n;
    endfunction

    task automatic clear_in();
        dis_en = '0; dis_rd = '0; redirect = 1'b0;
        wb_en = '0; wb_we = '0; wb_rd = '0;
        walk = 1'b0; walk_en = '0; walk_we = '0; walk_prd = '0;
        spec_en = '0; spec_rd = '0; spec_cancel = '0;
        preg = '0;
    endtask

    // Checks every output against the model for the current inputs, then advances one clock.
    task automatic cycle();
        @(negedge clk);
        check_eq("busy_count", 32'(busy_count), 32'(m_busy_total()));
        for (int i = 0; i < RD_PORTS; i++) begin
            int  p      = int'(preg[i]);
            bit  rdy    = m_rdy_hit(p);
            int  src    = m_spec_src(p);
            bit  killed = (m_kind[p] == 2) && spec_cancel[m_port[p]];
            bit  en     = ((m_kind[p] != 1) || rdy || (src >= 0)) && !killed;
            bit  sp     = en && !rdy && ((m_kind[p] == 2) || (src >= 0));
            check_eq($sformatf("rd%0d_en(p%0d)", i, p), 32'(reg_en[i]), 32'(en));
            check_eq($sformatf("rd%0d_spec(p%0d)", i, p), 32'(reg_spec[i]), 32'(sp));
        end
        for (int p = 0; p < PREG_SIZE; p++) begin
            int src = m_spec_src(p);
            n_kind[p] = m_kind[p];
            n_port[p] = m_port[p];
            n_last[p] = m_last[p];
            if (m_dis_hit(p)) begin
                n_kind[p] = 1;
            end else if (m_rdy_hit(p)) begin
                n_kind[p] = 0;
            end else if (src >= 0) begin
                n_kind[p] = 2;
                n_port[p] = src;
                n_last[p] = cyc + SPEC_DELAY;
            end else if (m_kind[p] == 2) begin
                if (spec_cancel[m_port[p]]) n_kind[p] = 1;
                else if (cyc == m_last[p]) n_kind[p] = 0;
            end
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < PREG_SIZE; p++) begin
            m_kind[p] = n_kind[p];
            m_port[p] = n_port[p];
            m_last[p] = n_last[p];
        end
        cyc++;
        clear_in();
    endtask

    function automatic logic [PREG_W-1:0] rand_preg();
        if ($urandom_range(0, 7) == 0) return PREG_W'($urandom_range(0, PREG_SIZE - 1));
        return PREG_W'($urandom_range(0, 15));
    endfunction

    task automatic rand_inputs();
        redirect = ($urandom_range(0, 15) == 0);
        for (int i = 0; i < DIS_WIDTH; i++) begin
            dis_en[i] = ($urandom_range(0, 3) == 0);
            dis_rd[i] = rand_preg();
        end
        for (int i = 0; i < WB_PORTS; i++) begin
            wb_en[i] = ($urandom_range(0, 3) == 0);
            wb_we[i] = ($urandom_range(0, 3) != 0);
            wb_rd[i] = rand_preg();
        end
        walk = ($urandom_range(0, 7) == 0);
        for (int i = 0; i < WALK_PORTS; i++) begin
            walk_en[i]  = ($urandom_range(0, 1) == 0);
            walk_we[i]  = ($urandom_range(0, 3) != 0);
            walk_prd[i] = rand_preg();
        end
        for (int j = 0; j < SPEC_PORTS; j++) begin
            spec_en[j]     = ($urandom_range(0, 2) == 0);
            spec_rd[j]     = rand_preg();
            spec_cancel[j] = !spec_en[j] && ($urandom_range(0, 4) == 0);
        end
        for (int i = 0; i < RD_PORTS; i++) preg[i] = rand_preg();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        for (int p = 0; p < PREG_SIZE; p++) begin
            m_kind[p] = 0; m_port[p] = 0; m_last[p] = 0;
        end
        clear_in();
        rst = 1'b0;
        #12 rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset state.
        preg[0] = 7'd0; preg[1] = 7'd5; preg[2] = 7'd127;
        #2;
        check_eq("rst_en0", 32'(reg_en[0]), 32'd1);
        check_eq("rst_en5", 32'(reg_en[1]), 32'd1);
        check_eq("rst_en127", 32'(reg_en[2]), 32'd1);
        check_eq("rst_spec", 32'(reg_spec[2:0]), 32'd0);
        check_eq("rst_busy", 32'(busy_count), 32'd0);
        cycle();

        // Dispatch 5 and 9, then writeback 5 with bypass.
        dis_en[0] = 1'b1; dis_rd[0] = 7'd5; dis_en[1] = 1'b1; dis_rd[1] = 7'd9;
        cycle();
        preg[0] = 7'd5; preg[1] = 7'd9;
        #2;
        check_eq("dis_en5", 32'(reg_en[0]), 32'd0);
        check_eq("dis_en9", 32'(reg_en[1]), 32'd0);
        check_eq("dis_busy2", 32'(busy_count), 32'd2);
        cycle();
        wb_en[0] = 1'b1; wb_we[0] = 1'b1; wb_rd[0] = 7'd5; preg[0] = 7'd5;
        #2;
        check_eq("wb_bypass5", 32'(reg_en[0]), 32'd1);
        cycle();
        preg[0] = 7'd5;
        #2;
        check_eq("wb_busy1", 32'(busy_count), 32'd1);
        check_eq("wb_state5", 32'(reg_en[0]), 32'd1);
        cycle();

        // Speculative wakeup of 7 from port 1, cancel on port 0 in the window.
        dis_en[0] = 1'b1; dis_rd[0] = 7'd7;
        cycle();
        spec_en[1] = 1'b1; spec_rd[1] = 7'd7; preg[0] = 7'd7;
        #2;
`ifdef PREG_READY_SPEC_WAKEUP_EN
        check_eq("spec_t0_en", 32'(reg_en[0]), 32'd1);
        check_eq("spec_t0_spec", 32'(reg_spec[0]), 32'd1);
`else
        check_eq("nospec_t0_en", 32'(reg_en[0]), 32'd0);
`endif
        cycle();
        spec_cancel[0] = 1'b1; preg[0] = 7'd7;
        #2;
`ifdef PREG_READY_SPEC_WAKEUP_EN
        check_eq("spec_t1_othercancel", 32'(reg_spec[0]), 32'd1);
`endif
        cycle();
        preg[0] = 7'd7;
        #2;
`ifdef PREG_READY_SPEC_WAKEUP_EN
        check_eq("spec_t2_spec", 32'(reg_spec[0]), 32'd1);
`endif
        cycle();
        spec_cancel[1] = 1'b1; preg[0] = 7'd7;
        #2;
`ifdef PREG_READY_SPEC_WAKEUP_EN
        check_eq("spec_t3_ready", 32'(reg_en[0]), 32'd1);
        check_eq("spec_t3_nospec", 32'(reg_spec[0]), 32'd0);
`else
        check_eq("nospec_t3_busy", 32'(reg_en[0]), 32'd0);
`endif
        cycle();

        // Same again, cancelled by its own port.
        dis_en[0] = 1'b1; dis_rd[0] = 7'd7;
        cycle();
        spec_en[1] = 1'b1; spec_rd[1] = 7'd7;
        cycle();
        spec_cancel[1] = 1'b1; preg[0] = 7'd7;
        #2;
        check_eq("cancel_en", 32'(reg_en[0]), 32'd0);
        cycle();
        preg[0] = 7'd7;
        #2;
        check_eq("cancel_busy", 32'(reg_en[0]), 32'd0);
        cycle();

        // Dispatch beats writeback; redirect masks dispatch.
        dis_en[2] = 1'b1; dis_rd[2] = 7'd12; wb_en[3] = 1'b1; wb_we[3] = 1'b1; wb_rd[3] = 7'd12;
        cycle();
        preg[0] = 7'd12;
        #2;
        check_eq("dis_over_wb", 32'(reg_en[0]), 32'd0);
        cycle();
        wb_en[0] = 1'b1; wb_we[0] = 1'b1; wb_rd[0] = 7'd12;
        cycle();
        dis_en[1] = 1'b1; dis_rd[1] = 7'd12; redirect = 1'b1;
        cycle();
        preg[0] = 7'd12;
        #2;
        check_eq("redirect_mask", 32'(reg_en[0]), 32'd1);
        cycle();

        // Preg 0 ignores dispatch; spec_en with same-port cancel leaves busy 9 busy.
        dis_en[0] = 1'b1; dis_rd[0] = 7'd0;
        spec_en[0] = 1'b1; spec_cancel[0] = 1'b1; spec_rd[0] = 7'd9; preg[1] = 7'd9;
        cycle();
        preg[0] = 7'd0; preg[1] = 7'd9;
        #2;
        check_eq("preg0_ready", 32'(reg_en[0]), 32'd1);
        check_eq("preg9_kept", 32'(reg_en[1]), 32'd0);
        check_eq("preg0_busy", 32'(busy_count), 32'd2);
        cycle();

        // Walk restores four busy pregs at once.
        for (int i = 0; i < 4; i++) begin
            dis_en[i] = 1'b1; dis_rd[i] = PREG_W'(30 + i);
        end
        cycle();
        walk = 1'b1; redirect = 1'b1;
        dis_en[0] = 1'b1; dis_rd[0] = 7'd40;
        for (int i = 0; i < 4; i++) begin
            walk_en[i] = 1'b1; walk_we[i] = 1'b1; walk_prd[i] = PREG_W'(30 + i);
        end
        #2;
        check_eq("walk_before", 32'(busy_count), 32'd6);
        cycle();
        #2;
        check_eq("walk_after", 32'(busy_count), 32'd2);
        cycle();

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rand_inputs();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
